// File: rtl/overture_pkg.sv
// overture_pkg: shared types and constants for the Overture sequencer
package overture_pkg;
  typedef enum logic [1:0] {IMM, CALC, COPY, COND} mode_t;
  typedef enum logic [1:0] {FETCH, EXEC, WAIT_IN, WAIT_OUT} ctrl_state_t;
  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] CC_NEVER = 3'd0;
  localparam logic [2:0] CC_EQZ   = 3'd1;
  localparam logic [2:0] CC_LTZ   = 3'd2;
  localparam logic [2:0] CC_LEZ   = 3'd3;
  localparam logic [2:0] CC_ALWAYS = 3'd4;
  localparam logic [2:0] CC_NEZ   = 3'd5;
  localparam logic [2:0] CC_GEZ   = 3'd6;
  localparam logic [2:0] CC_GTZ   = 3'd7;
  localparam logic [2:0] REG_IO   = 3'd6;
  localparam logic [2:0] REG_NULL = 3'd7;
endpackage

// File: rtl/overture_cond_eval.sv
// overture_cond_eval: signed test of a value against a 3-bit condition code
module overture_cond_eval
  import overture_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [2:0] code_i,
  output logic       taken_o
);
  logic z, n;
  // zero/negative flags selected by the condition code
  always_comb begin
    z = value_i == 8'd0;
    n = value_i[7];
    taken_o = code_i == CC_NEVER  ? 1'b0 :
              code_i == CC_EQZ    ? z :
              code_i == CC_LTZ    ? n :
              code_i == CC_LEZ    ? (n | z) :
              code_i == CC_ALWAYS ? 1'b1 :
              code_i == CC_NEZ    ? !z :
              code_i == CC_GEZ    ? !n : !(n | z);
  end
endmodule

// File: rtl/overture_ctrl.sv
// overture_ctrl: Overture CPU instruction sequencer; conditional jumps enabled by OVERTURE_COND_EN
module overture_ctrl
  import overture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] pc,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_data,
  output logic [DATA_W-1:0] alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);
  ctrl_state_t       state_q;
  logic [DATA_W-1:0] pc_q, instr_q, out_data_q, pc_inc;
  logic [DATA_W-1:0] regs_q [8];
  logic              out_valid_q, taken;
  mode_t             mode;
  logic [2:0]        src, dst;
`ifdef OVERTURE_COND_EN
  overture_cond_eval u_cond (.value_i(regs_q[3]), .code_i(instr_q[2:0]), .taken_o(taken));
`else
  assign taken = 1'b0;
`endif
  // decode fields and drive the ALU / port handshakes
  always_comb begin
    mode      = mode_t'(instr_q[7:6]);
    src       = instr_q[5:3];
    dst       = instr_q[2:0];
    pc_inc    = pc_q + 1'b1;
    pc        = pc_q;
    instr_req = state_q == FETCH;
    alu_op    = (state_q == EXEC && mode == CALC) ? {5'b0, instr_q[2:0]} : '0;
    alu_a     = regs_q[1];
    alu_b     = regs_q[2];
    in_ready  = state_q == WAIT_IN && in_valid;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end
  // sequencer FSM; entries 6 and 7 of regs_q are never written and read as 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        FETCH: if (instr_valid) begin
          instr_q <= instr_data;
          state_q <= EXEC;
        end
        EXEC: begin
          state_q <= FETCH;
          pc_q    <= pc_inc;
          case (mode)
            IMM:  regs_q[0] <= {2'b00, instr_q[5:0]};
            CALC: regs_q[3] <= alu_result;
            COND: pc_q <= taken ? regs_q[0] : pc_inc;
            COPY: if (src == REG_IO) begin
              pc_q    <= pc_q;
              state_q <= WAIT_IN;
            end else if (dst == REG_IO) begin
              pc_q        <= pc_q;
              out_data_q  <= regs_q[src];
              out_valid_q <= 1'b1;
              state_q     <= WAIT_OUT;
            end else if (dst < REG_IO) regs_q[dst] <= regs_q[src];
          endcase
        end
        WAIT_IN: if (in_valid) begin
          if (dst == REG_IO) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= WAIT_OUT;
          end else begin
            if (dst != REG_NULL) regs_q[dst] <= in_data;
            pc_q    <= pc_inc;
            state_q <= FETCH;
          end
        end
        WAIT_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          pc_q        <= pc_inc;
          state_q     <= FETCH;
        end
      endcase
    end
  end
endmodule
